// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: opcodes, functs,
// ALU control codes, internal ALU-op selects and the FSM state enum.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // What the FSM asks of the ALU decoder; FUNCT defers to the instruction's funct field.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALU-op request (and the funct field for R-type) to alu_ctrl,
// flagging funct codes the datapath does not implement.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_ok_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    funct_ok_o = 1'b1;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_OR:  alu_ctrl_o = ALU_OR;
      default: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_ok_o = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with sticky illegal-instruction flag.
// Define ORI_ZEXT_EN to add ori (zero-extended immediate OR).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ext_zero,
  output logic       illegal
);

  if (STATE_W < 4) begin : g_state_w_check
    $error("multicycle_control: STATE_W must be at least 4");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;
  state_e             state, nxt;
  logic [1:0]         alu_op;
  logic               funct_ok;
  logic               ir_write_s, pc_write, branch;

  assign state = state_e'(state_q[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_W'(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    nxt       = state;
    illegal_d = illegal_q;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_IMMEX;
          OP_J:         nxt = S_JUMP;
`ifdef ORI_ZEXT_EN
          OP_ORI:       nxt = S_IMMEX;
`endif
          default: begin
            nxt       = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC: begin
        if (funct_ok) begin
          nxt = S_ALUWB;
        end else begin
          nxt       = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_IMMEX:  nxt = S_IMMWB;
      default:  nxt = S_FETCH;
    endcase
    state_d = STATE_W'(nxt);
  end

  // Moore outputs; only ir_write/pc_write in FETCH and branch look at inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write_s = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write_s = mem_ready;
        alu_src_b  = 2'b01;
        pc_write   = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
`ifdef ORI_ZEXT_EN
        if (op == OP_ORI) alu_op = ALUOP_OR;
`endif
      end
      S_IMMWB:  reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset must never let a half-fetched instruction load IR or PC.
  assign ir_write = rst_n & ir_write_s;
  assign pc_en    = rst_n & (pc_write | (branch & zero));
  assign illegal  = illegal_q;

`ifdef ORI_ZEXT_EN
  assign ext_zero = ((state == S_IMMEX) || (state == S_IMMWB)) && (op == OP_ORI);
`else
  assign ext_zero = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl),
    .funct_ok_o (funct_ok)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors
// are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3, T_MEMWB = 4, T_MEMWR = 5;
  localparam int T_EXEC = 6, T_ALUWB = 7, T_BRANCH = 8, T_IMMEX = 9, T_IMMWB = 10, T_JUMP = 11;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100;
  localparam logic [5:0] O_ADDI = 6'b001000, O_J = 6'b000010, O_ORI = 6'b001101, O_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b000111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       pc_en, ext_zero, illegal;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .ext_zero(ext_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_write,iord,ir_write,reg_write,reg_dst,mem_to_reg,alu_src_a,
  //  alu_src_b,alu_ctrl,pc_src,pc_en,ext_zero,illegal}
  logic [17:0] obs;
  assign obs = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, alu_ctrl, pc_src, pc_en, ext_zero, illegal};

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_ill = 1'b0;

  task automatic check_eq(input string tag, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  function automatic string st_name(input int st);
    case (st)
      T_FETCH:  return "FETCH";
      T_DECODE: return "DECODE";
      T_MEMADR: return "MEMADR";
      T_MEMRD:  return "MEMRD";
      T_MEMWB:  return "MEMWB";
      T_MEMWR:  return "MEMWR";
      T_EXEC:   return "EXEC";
      T_ALUWB:  return "ALUWB";
      T_BRANCH: return "BRANCH";
      T_IMMEX:  return "IMMEX";
      T_IMMWB:  return "IMMWB";
      default:  return "JUMP";
    endcase
  endfunction

  // {funct valid, alu_ctrl}
  function automatic logic [3:0] fdec(input logic [5:0] f);
    case (f)
      F_ADD:   return 4'b1_010;
      F_SUB:   return 4'b1_110;
      F_AND:   return 4'b1_000;
      F_OR:    return 4'b1_001;
      F_SLT:   return 4'b1_111;
      default: return 4'b0_010;
    endcase
  endfunction

  function automatic logic [17:0] model(input int st, input logic [5:0] o, input logic [5:0] f,
                                        input logic z, input logic rdy, input logic rst,
                                        input logic ill);
    logic mreq, mwr, ia, irw, rw, rdst, m2r, asa, pce, ez;
    logic [1:0] asb, psrc;
    logic [2:0] actl;
    logic [3:0] fd;
    mreq = 0; mwr = 0; ia = 0; irw = 0; rw = 0; rdst = 0; m2r = 0; asa = 0; pce = 0; ez = 0;
    asb = 2'b00; psrc = 2'b00; actl = 3'b010;
    fd = fdec(f);
    case (st)
      T_FETCH:  begin mreq = 1; irw = rdy & ~rst; asb = 2'b01; pce = rdy & ~rst; end
      T_DECODE: asb = 2'b11;
      T_MEMADR: begin asa = 1; asb = 2'b10; end
      T_MEMRD:  begin mreq = 1; ia = 1; end
      T_MEMWB:  begin rw = 1; m2r = 1; end
      T_MEMWR:  begin mreq = 1; mwr = 1; ia = 1; end
      T_EXEC:   begin asa = 1; actl = fd[2:0]; end
      T_ALUWB:  begin rw = 1; rdst = 1; end
      T_BRANCH: begin asa = 1; actl = 3'b110; psrc = 2'b01; pce = z; end
      T_IMMEX: begin
        asa = 1; asb = 2'b10;
`ifdef ORI_ZEXT_EN
        if (o == O_ORI) begin actl = 3'b001; ez = 1; end
`endif
      end
      T_IMMWB: begin
        rw = 1;
`ifdef ORI_ZEXT_EN
        ez = (o == O_ORI);
`endif
      end
      default:  begin psrc = 2'b10; pce = 1; end
    endcase
    return {mreq, mwr, ia, irw, rw, rdst, m2r, asa, asb, actl, psrc, pce, ez, ill};
  endfunction

  task automatic step(input string nm, input int st, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic rdy, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    op = o; funct = f; zero = z; mem_ready = rdy; rst_n = ~rst;
    if (rst) exp_ill = 1'b0;
    e.tag = {nm, "/", st_name(st)};
    e.v   = model(st, o, f, z, rdy, rst, exp_ill);
    sb.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(nm, T_FETCH, o, f, z, 1'b0, 1'b0);
    step(nm, T_FETCH, o, f, z, 1'b1, 1'b0);
    step(nm, T_DECODE, o, f, z, rnd(), 1'b0);
    case (o)
      O_LW: begin
        step(nm, T_MEMADR, o, f, z, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) step(nm, T_MEMRD, o, f, z, 1'b0, 1'b0);
        step(nm, T_MEMRD, o, f, z, 1'b1, 1'b0);
        step(nm, T_MEMWB, o, f, z, rnd(), 1'b0);
      end
      O_SW: begin
        step(nm, T_MEMADR, o, f, z, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) step(nm, T_MEMWR, o, f, z, 1'b0, 1'b0);
        step(nm, T_MEMWR, o, f, z, 1'b1, 1'b0);
      end
      O_R: begin
        step(nm, T_EXEC, o, f, z, rnd(), 1'b0);
        if (fdec(f) >= 4'b1000) step(nm, T_ALUWB, o, f, z, rnd(), 1'b0);
        else exp_ill = 1'b1;
      end
      O_BEQ:  step(nm, T_BRANCH, o, f, z, rnd(), 1'b0);
      O_ADDI: begin
        step(nm, T_IMMEX, o, f, z, rnd(), 1'b0);
        step(nm, T_IMMWB, o, f, z, rnd(), 1'b0);
      end
      O_J:    step(nm, T_JUMP, o, f, z, rnd(), 1'b0);
`ifdef ORI_ZEXT_EN
      O_ORI: begin
        step(nm, T_IMMEX, o, f, z, rnd(), 1'b0);
        step(nm, T_IMMWB, o, f, z, rnd(), 1'b0);
      end
`endif
      default: exp_ill = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_eq(mon_e.tag, obs, mon_e.v);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    step("rst", T_FETCH, O_BAD, F_BAD, 1'b1, 1'b1, 1'b1);
    step("rst", T_FETCH, O_LW, F_ADD, 1'b1, 1'b1, 1'b1);

    run_instr("add",  O_R,    F_ADD, 1'b0, 0, 0);
    run_instr("sub",  O_R,    F_SUB, 1'b1, 1, 0);
    run_instr("lw",   O_LW,   F_ADD, 1'b0, 0, 2);
    run_instr("sw",   O_SW,   F_ADD, 1'b0, 0, 1);
    run_instr("beq1", O_BEQ,  F_ADD, 1'b1, 0, 0);
    run_instr("beq0", O_BEQ,  F_ADD, 1'b0, 0, 0);
    run_instr("addi", O_ADDI, F_OR,  1'b0, 0, 0);
    run_instr("j",    O_J,    F_ADD, 1'b1, 2, 0);
    run_instr("and",  O_R,    F_AND, 1'b0, 0, 0);
    run_instr("or",   O_R,    F_OR,  1'b0, 0, 0);
    run_instr("slt",  O_R,    F_SLT, 1'b0, 0, 0);
    run_instr("ori",  O_ORI,  F_ADD, 1'b0, 0, 0);

    step("rst2", T_FETCH, O_R, F_ADD, 1'b0, 1'b1, 1'b1);
    run_instr("bad",  O_BAD,  F_ADD, 1'b0, 0, 0);
    run_instr("add2", O_R,    F_ADD, 1'b0, 0, 0);
    run_instr("badf", O_R,    F_BAD, 1'b0, 0, 0);
    step("rst3", T_FETCH, O_R, F_ADD, 1'b0, 1'b0, 1'b1);

    step("swrst", T_FETCH,  O_SW, F_ADD, 1'b0, 1'b1, 1'b0);
    step("swrst", T_DECODE, O_SW, F_ADD, 1'b0, 1'b0, 1'b0);
    step("swrst", T_MEMADR, O_SW, F_ADD, 1'b0, 1'b1, 1'b0);
    step("swrst", T_MEMWR,  O_SW, F_ADD, 1'b0, 1'b0, 1'b0);
    step("swrst", T_FETCH,  O_SW, F_ADD, 1'b0, 1'b1, 1'b1);
    run_instr("add3", O_R,  F_ADD, 1'b0, 1, 0);
    run_instr("j2",   O_J,  F_ADD, 1'b0, 0, 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 STATE_W, 4, width of the state register; the module SHALL NOT accept values below 4.
REQ-002 clk  input  1  rising-edge clock for the single clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  6  opcode field ir[31:26] of the instruction register.
REQ-005 funct  input  6  function field ir[5:0] of the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completion strobe for the current access.
REQ-008 mem_req, mem_write, iord  output  1 each  memory request, write enable and address select (0=PC, 1=ALUOut).
REQ-009 ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath enables and selects.
REQ-010 alu_src_b  output  2  00=B, 01=const 4, 10=sign/zero-extended imm, 11=ext imm<<2.
REQ-011 alu_ctrl  output  3  010=add, 110=sub, 000=and, 001=or, 111=slt.
REQ-012 pc_src  output  2  00=ALU, 01=ALUOut, 10=jump target.
REQ-013 pc_en  output  1  PC load (pc_write OR (branch AND zero)).
REQ-014 ext_zero  output  1  imm extension select, 1=zero-extend, 0=sign-extend.
REQ-015 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB and JUMP.
REQ-017 FETCH SHALL assert mem_req=1, iord=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00, pc_en=mem_ready.
REQ-018 FETCH SHALL hold until mem_ready=1 and then go to DECODE; IR and PC SHALL be updated only on the ready cycle.
REQ-019 DECODE SHALL compute the branch target with alu_src_b=11, alu_ctrl=010.
REQ-020 DECODE SHALL dispatch as follows: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 001000 to IMMEX, 000010 to JUMP.
REQ-021 DECODE SHALL send any other opcode to FETCH, set illegal=1 and not write the register file.
REQ-022 MEMADR SHALL use alu_src_a=1, alu_src_b=10, alu_ctrl=010, then go to MEMRD for lw or MEMWR for sw.
REQ-023 MEMRD SHALL assert mem_req=1, iord=1, waiting for mem_ready, then go to MEMWB.
REQ-024 MEMWB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-025 MEMWR SHALL assert mem_req=1, mem_write=1, iord=1, waiting for mem_ready, then go to FETCH.
REQ-026 EXEC SHALL decode funct 100000/100010/100100/100101/101010 to add/sub/and/or/slt, then go to ALUWB.
REQ-027 An unknown funct in EXEC SHALL set illegal=1 and return to FETCH without reaching ALUWB.
REQ-028 ALUWB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-029 BRANCH SHALL use alu_ctrl=110, pc_src=01, pc_en=zero, then go to FETCH.
REQ-030 JUMP SHALL use pc_src=10, pc_en=1, then go to FETCH.
REQ-031 IMMEX SHALL use alu_src_b=10 and the opcode's ALU op; IMMWB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-032 Zero-wait instruction latency SHALL be: lw 5, sw/R-type/addi 4, beq/j 3 cycles.
REQ-033 Each memory wait cycle SHALL add exactly one cycle to that latency.
REQ-034 Outputs SHALL be Moore functions of state, except pc_en, ir_write and state advance, which are gated by zero/mem_ready.
REQ-035 mem_req SHALL stay high throughout every wait state.
REQ-036 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-037 ext_zero SHALL be 0 in all states unless REQ-041 applies.

Reset
REQ-038 On rst_n=0, state SHALL become FETCH asynchronously and illegal SHALL clear to 0.
REQ-039 Reset asserted mid-instruction SHALL abandon the instruction with no register or memory write; all outputs SHALL show FETCH values with pc_en=0 and ir_write=0 while reset is held.

Configuration
REQ-040 The macro ORI_ZEXT_EN SHALL control support for ori (opcode 001101).
REQ-041 With ORI_ZEXT_EN defined, ori SHALL dispatch to IMMEX with alu_ctrl=001, and ext_zero=1 SHALL hold in IMMEX and IMMWB.
REQ-042 Without ORI_ZEXT_EN, 001101 SHALL be illegal per REQ-021, and ext_zero SHALL be tied to 0.

Structure
REQ-043 A shared package/header SHALL hold the opcode, funct, alu_ctrl and state encoding constants and the ALU-op localparams.
REQ-044 The funct/ALU-op to alu_ctrl decode SHALL be a sub-module named alu_decoder; the FSM SHALL stay in multicycle_control.

Verification
REQ-045 add (op 000000, funct 100000) with mem_ready tied 1: reg_write=1, reg_dst=1 in cycle 4; FETCH in cycle 5.
REQ-046 lw with mem_ready low for 2 cycles in MEMRD: total 7 cycles, mem_req held high, mem_to_reg=1 in MEMWB.
REQ-047 beq with zero=1: pc_en=1, pc_src=01 in cycle 3; with zero=0: pc_en=0.
REQ-048 op 111111: illegal=1 after DECODE and stays 1 through the next add; rst_n low clears it.
REQ-049 rst_n pulsed low during MEMWR: no mem_write after release, state=FETCH.
REQ-050 With ORI_ZEXT_EN defined, ori gives ext_zero=1, alu_ctrl=001 in IMMEX; without the macro, illegal=1.
